// File: rtl/ifetch_unit_if.sv
// ---------------------------------------------------------------------------
// ifetch_unit_if
//   Instruction-memory read port used by the fetch sequencer.
//   mem_req   : read request, held high for the whole request phase
//   mem_addr  : word address, stable while mem_req is high
//   mem_ack   : memory accepts the request; mem_rdata is valid this cycle
//   mem_rdata : returned instruction word
//   master = fetch unit side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface ifetch_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/ifetch_unit.sv
// ---------------------------------------------------------------------------
// ifetch_unit
//   Instruction-fetch sequencer for the multicycle MIPS core. On a start
//   pulse it reads the PC, issues one word read to instruction memory,
//   latches the word into the instruction register and then pulses pc_we
//   with npc = PC + 4 so the PC register advances.
//
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     pc_q        : current PC register value
//     start       : fetch request, only looked at while idle
//     fault_clr   : clears the sticky fault flag
//     mem         : instruction-memory read port (master side)
//     ir          : instruction register
//     npc         : next PC, feeds the PC register write port
//     pc_we, done : one-cycle completion pulse
//     busy        : a fetch is in progress
//     fault       : sticky misaligned-PC or memory-timeout flag
// ---------------------------------------------------------------------------
module ifetch_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        pc_q,
  input  logic               start,
  input  logic               fault_clr,
  ifetch_unit_if.master      mem,
  output logic [31:0]        ir,
  output logic [31:0]        npc,
  output logic               pc_we,
  output logic               done,
  output logic               busy,
  output logic               fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    UPD
  } state_t;

  // Timer value reached on the last request cycle that may still be acked.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] ir_q,    ir_d;
  logic [31:0] npc_q,   npc_d;
  logic [7:0]  timer_q, timer_d;
  logic        fault_q, fault_d;
  logic        new_fault;

  // Next-state logic. A misaligned start is treated as a fault condition
  // even while fault is already set, so that a clear arriving together
  // with a fresh misaligned request leaves the flag set.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    npc_d     = npc_q;
    timer_d   = timer_q;
    new_fault = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (pc_q[1:0] != 2'b00) begin
            new_fault = 1'b1;
          end else if (!fault_q) begin
            addr_d  = pc_q;
            timer_d = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (mem.mem_ack) begin
          ir_d    = mem.mem_rdata;
          npc_d   = addr_q + 32'd4;
          state_d = UPD;
        end else if (timer_q == TIMER_LAST) begin
          new_fault = 1'b1;
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      UPD: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    fault_d = new_fault | (fault_q & ~fault_clr);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= 32'd0;
      ir_q    <= 32'd0;
      npc_q   <= 32'd0;
      timer_q <= 8'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      npc_q   <= npc_d;
      timer_q <= timer_d;
      fault_q <= fault_d;
    end
  end

  // All control outputs are pure decodes of the state register.
  assign mem.mem_req  = (state_q == REQ);
  assign mem.mem_addr = addr_q;
  assign pc_we        = (state_q == UPD);
  assign done         = (state_q == UPD);
  assign busy         = (state_q != IDLE);
  assign ir           = ir_q;
  assign npc          = npc_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// ---------------------------------------------------------------------------
// tb_ifetch_unit
//   Self-checking bench for ifetch_unit: a directed vector table, hand
//   sequences for wait states, timeout and reset during a request, and a
//   randomized run compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_ifetch_unit;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        fault_clr;
  logic [31:0] pc_q;
  logic [31:0] ir;
  logic [31:0] npc;
  logic        pc_we;
  logic        done;
  logic        busy;
  logic        fault;

  int vectors     = 0;
  int miscompares = 0;

  ifetch_unit_if mem_bus ();

  ifetch_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_q      (pc_q),
    .start     (start),
    .fault_clr (fault_clr),
    .mem       (mem_bus),
    .ir        (ir),
    .npc       (npc),
    .pc_we     (pc_we),
    .done      (done),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clk = ~clk;

  // Reference model: a fetch is either outstanding (with a count of
  // unanswered request cycles), finishing (PC write cycle), or absent.
  bit          m_valid    = 1'b0;
  bit          m_fetching = 1'b0;
  bit          m_updating = 1'b0;
  int          m_waited   = 0;
  logic [31:0] m_addr     = 32'd0;
  logic [31:0] m_ir       = 32'd0;
  logic [31:0] m_npc      = 32'd0;
  bit          m_fault    = 1'b0;

  typedef struct {
    logic        rst;
    logic        st;
    logic        clr;
    logic        ack;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic        e_req;
    logic        e_we;
    logic        e_fault;
    logic [31:0] e_ir;
    logic [31:0] e_npc;
  } vec_t;

  vec_t tbl[14];

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_inputs(input logic r, input logic s, input logic c, input logic a,
                            input logic [31:0] p, input logic [31:0] d);
    reset             = r;
    start             = s;
    fault_clr         = c;
    mem_bus.mem_ack   = a;
    pc_q              = p;
    mem_bus.mem_rdata = d;
  endtask

  // Compare every DUT output against the model's view of this cycle.
  task automatic check_output();
    if (m_valid) begin
      chk1 ("model_mem_req",  mem_bus.mem_req, m_fetching);
      chk32("model_mem_addr", mem_bus.mem_addr, m_addr);
      chk32("model_ir",       ir,    m_ir);
      chk32("model_npc",      npc,   m_npc);
      chk1 ("model_pc_we",    pc_we, m_updating);
      chk1 ("model_done",     done,  m_updating);
      chk1 ("model_busy",     busy,  m_fetching | m_updating);
      chk1 ("model_fault",    fault, m_fault);
    end
  endtask

  // Clock edge: advance the model with the inputs held during the cycle.
  task automatic tick();
    bit nf;
    @(posedge clk);
    nf = 1'b0;
    if (reset) begin
      m_fetching = 1'b0;
      m_updating = 1'b0;
      m_waited   = 0;
      m_addr     = 32'd0;
      m_ir       = 32'd0;
      m_npc      = 32'd0;
      m_fault    = 1'b0;
      m_valid    = 1'b1;
    end else begin
      if (m_updating) begin
        m_updating = 1'b0;
      end else if (m_fetching) begin
        if (mem_bus.mem_ack) begin
          m_ir       = mem_bus.mem_rdata;
          m_npc      = m_addr + 32'd4;
          m_fetching = 1'b0;
          m_updating = 1'b1;
        end else if (m_waited + 1 == TIMEOUT) begin
          m_fetching = 1'b0;
          nf         = 1'b1;
        end else begin
          m_waited++;
        end
      end else if (start) begin
        if (pc_q % 4 != 0) begin
          nf = 1'b1;
        end else if (!m_fault) begin
          m_addr     = pc_q;
          m_fetching = 1'b1;
          m_waited   = 0;
        end
      end
      m_fault = nf | (m_fault & !fault_clr);
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic s, input logic c, input logic a,
                                input logic [31:0] p, input logic [31:0] d);
    @(negedge clk);
    set_inputs(r, s, c, a, p, d);
    check_output();
  endtask

  task automatic cycle(input logic r, input logic s, input logic c, input logic a,
                       input logic [31:0] p, input logic [31:0] d);
    apply_stimulus(r, s, c, a, p, d);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] pc_w;
    logic [31:0] rd_w;
    logic [31:0] saved_ir;
    logic [31:0] saved_npc;
    logic [31:0] p;
    int          req_cycles;

    // Expected outputs are those observed during the row's own cycle.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00400000, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400000, 32'h8C080004, 1'b1, 1'b0, 1'b0, 32'h0,        32'h0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00400000, 32'h0,        1'b0, 1'b1, 1'b0, 32'h8C080004, 32'h00400004};
    tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b0, 1'b0, 32'h8C080004, 32'h00400004};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h12345678, 1'b1, 1'b0, 1'b0, 32'h8C080004, 32'h00400004};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,        1'b0, 1'b1, 1'b0, 32'h12345678, 32'h00000000};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00400002, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h00000000};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00400008, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 32'h00000000};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h00400008, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h00000000};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00400008, 32'h0,        1'b0, 1'b0, 1'b1, 32'h12345678, 32'h00000000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00400008, 32'h0,        1'b0, 1'b0, 1'b0, 32'h12345678, 32'h00000000};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h00400008, 32'h24020001, 1'b1, 1'b0, 1'b0, 32'h12345678, 32'h00000000};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00400008, 32'h0,        1'b0, 1'b1, 1'b0, 32'h24020001, 32'h0040000C};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00400008, 32'h0,        1'b0, 1'b0, 1'b0, 32'h24020001, 32'h0040000C};

    set_inputs(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();

    // Directed table: zero-wait fetch, wrap, misaligned fault and clear.
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(tbl[i].rst, tbl[i].st, tbl[i].clr, tbl[i].ack, tbl[i].pc, tbl[i].rdata);
      chk1 ($sformatf("tbl%0d_mem_req", i), mem_bus.mem_req, tbl[i].e_req);
      chk1 ($sformatf("tbl%0d_pc_we", i),   pc_we,           tbl[i].e_we);
      chk1 ($sformatf("tbl%0d_done", i),    done,            tbl[i].e_we);
      chk1 ($sformatf("tbl%0d_fault", i),   fault,           tbl[i].e_fault);
      chk32($sformatf("tbl%0d_ir", i),      ir,              tbl[i].e_ir);
      chk32($sformatf("tbl%0d_npc", i),     npc,             tbl[i].e_npc);
      tick();
    end

    // Wait states: ack on the 4th request cycle, start pulses ignored.
    pc_w = $urandom;
    pc_w[1:0] = 2'b00;
    rd_w = $urandom;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, pc_w, 32'h0);
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(1'b0, 1'b1, 1'b0, (k == 3), pc_w ^ 32'h00001000, rd_w);
      chk1 ($sformatf("wait_req_c%0d", k + 1), mem_bus.mem_req, 1'b1);
      chk32($sformatf("wait_addr_c%0d", k + 1), mem_bus.mem_addr, pc_w);
      chk1 ($sformatf("wait_we_c%0d", k + 1), pc_we, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, pc_w, 32'h0);
    chk1 ("wait_we_c5", pc_we, 1'b1);
    chk32("wait_ir", ir, rd_w);
    chk32("wait_npc", npc, pc_w + 32'd4);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, pc_w, 32'h0);
    chk1 ("wait_no_queued_start", busy, 1'b0);
    tick();

    // Timeout: no ack ever; mem_req must stay high for TIMEOUT cycles.
    saved_ir  = m_ir;
    saved_npc = m_npc;
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h00400100, 32'h0);
    req_cycles = 0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h00400100, 32'h0);
    while (mem_bus.mem_req === 1'b1 && req_cycles < 40) begin
      req_cycles++;
      tick();
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h00400100, 32'h0);
    end
    chk32("timeout_req_cycles", req_cycles, 32'd16);
    chk1 ("timeout_fault", fault, 1'b1);
    chk1 ("timeout_idle", busy, 1'b0);
    chk32("timeout_ir_kept", ir, saved_ir);
    chk32("timeout_npc_kept", npc, saved_npc);
    tick();
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'h00400102, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("clr_vs_new_fault", fault, 1'b1);
    tick();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    chk1("clr_alone", fault, 1'b0);
    tick();

    // Reset two cycles into a pending fetch, then a late ack.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h00400200, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h00400200, 32'h0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h00400200, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h00400200, 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h00400200, 32'hCAFEF00D);
    chk1 ("rst_req", mem_bus.mem_req, 1'b0);
    chk32("rst_addr", mem_bus.mem_addr, 32'h0);
    chk32("rst_ir", ir, 32'h0);
    chk32("rst_npc", npc, 32'h0);
    chk1 ("rst_we", pc_we, 1'b0);
    chk1 ("rst_busy", busy, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h00400200, 32'h0);
    chk32("late_ack_ir", ir, 32'h0);
    chk1 ("late_ack_we", pc_we, 1'b0);
    tick();

    // Randomized run against the reference model.
    for (int n = 0; n < 2000; n++) begin
      p = $urandom;
      if ($urandom_range(7) != 0) p[1:0] = 2'b00;
      cycle(($urandom_range(63) == 0), ($urandom_range(3) == 0), ($urandom_range(15) == 0),
            ($urandom_range(2) == 0), p, $urandom);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
